// File: rtl/fetch_pkg.sv
// Shared types and constants for the LEGv8 instruction-fetch stage.
package fetch_pkg;

    typedef enum logic [1:0] {
        REQ  = 2'd0,
        HOLD = 2'd1,
        DROP = 2'd2
    } fetch_state_t;

    localparam logic [31:0] INSTR_BUBBLE = 32'h0000_0000;
    localparam int unsigned PC_INC       = 32'd4;
    localparam int          OP_MSB       = 31;
    localparam int          OP_LSB       = 21;

    // Saturating increment used by the optional performance counters.
    function automatic logic [31:0] sat_inc32(input logic [31:0] value);
        logic [31:0] result;
        if (value == 32'hFFFF_FFFF) begin
            result = value;
        end else begin
            result = value + 32'd1;
        end
        return result;
    endfunction

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register: bubble has priority over load; otherwise contents hold.
module if_id_reg
    import fetch_pkg::*;
#(
    parameter int N = 64
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         load,
    input  logic         bubble,
    input  logic [N-1:0] pc_in,
    input  logic [31:0]  instr_in,
    output logic [N-1:0] pc,
    output logic [31:0]  instr,
    output logic         valid
);

    // Pipeline register; a bubble keeps the old PC but clears instruction and valid.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc    <= {N{1'b0}};
            instr <= INSTR_BUBBLE;
            valid <= 1'b0;
        end else if (bubble) begin
            instr <= INSTR_BUBBLE;
            valid <= 1'b0;
        end else if (load) begin
            pc    <= pc_in;
            instr <= instr_in;
            valid <= 1'b1;
        end else begin
            valid <= valid;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// LEGv8 fetch stage: PC, imem req/ready handshake, stall/redirect handling, IF/ID register.
// Optional macro FETCH_PERF_CNT_EN adds saturating fetched/bubble counters.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter int           N        = 64,
    parameter logic [N-1:0] PC_RESET = {N{1'b0}}
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         stall_i,
    input  logic         PCSrc_i,
    input  logic [N-1:0] branch_target_i,
    output logic         imem_req_o,
    output logic [N-1:0] imem_addr_o,
    input  logic         imem_ready_i,
    input  logic [31:0]  imem_rdata_i,
    output logic [N-1:0] IF_ID_pc_o,
    output logic [31:0]  IF_ID_instr_o,
    output logic         IF_ID_valid_o,
    output logic [10:0]  Op_o
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]  fetched_cnt_o,
    output logic [31:0]  bubble_cnt_o
`endif
);

    fetch_state_t state_r, state_s;
    logic [N-1:0] pc_r, pc_s;
    logic [N-1:0] hold_pc_r, hold_pc_s;
    logic [31:0]  hold_instr_r, hold_instr_s;
    logic [N-1:0] drop_addr_r, drop_addr_s;
    logic         req_s;
    logic         ready_s;
    logic         load_s;
    logic         bubble_s;
    logic [N-1:0] load_pc_s;
    logic [31:0]  load_instr_s;

    // Request is gated by reset so nothing is issued while reset is held.
    assign imem_req_o  = req_s & reset_n;
    assign imem_addr_o = (state_r == DROP) ? drop_addr_r : pc_r;
    assign Op_o        = IF_ID_instr_o[OP_MSB:OP_LSB];

    // Next-state, PC and IF/ID control decode; redirect outranks stall everywhere.
    always_comb begin
        state_s      = state_r;
        pc_s         = pc_r;
        hold_pc_s    = hold_pc_r;
        hold_instr_s = hold_instr_r;
        drop_addr_s  = drop_addr_r;
        load_s       = 1'b0;
        bubble_s     = 1'b0;
        load_pc_s    = pc_r;
        load_instr_s = imem_rdata_i;
        req_s        = (state_r != HOLD);
        ready_s      = imem_ready_i & req_s;
        case (state_r)
            REQ: begin
                if (PCSrc_i) begin
                    bubble_s = 1'b1;
                    pc_s     = branch_target_i;
                    if (ready_s) begin
                        state_s = REQ;
                    end else begin
                        // The old request is still in flight; remember its address.
                        state_s     = DROP;
                        drop_addr_s = pc_r;
                    end
                end else if (ready_s) begin
                    pc_s = pc_r + N'(PC_INC);
                    if (stall_i) begin
                        hold_pc_s    = pc_r;
                        hold_instr_s = imem_rdata_i;
                        state_s      = HOLD;
                    end else begin
                        load_s = 1'b1;
                    end
                end else if (!stall_i) begin
                    bubble_s = 1'b1;
                end else begin
                    bubble_s = 1'b0;
                end
            end
            HOLD: begin
                if (PCSrc_i) begin
                    bubble_s = 1'b1;
                    pc_s     = branch_target_i;
                    state_s  = REQ;
                end else if (!stall_i) begin
                    load_s       = 1'b1;
                    load_pc_s    = hold_pc_r;
                    load_instr_s = hold_instr_r;
                    state_s      = REQ;
                end else begin
                    state_s = HOLD;
                end
            end
            DROP: begin
                if (PCSrc_i) begin
                    pc_s = branch_target_i;
                end else begin
                    pc_s = pc_r;
                end
                if (ready_s) begin
                    state_s = REQ;
                end else begin
                    state_s = DROP;
                end
            end
            default: begin
                state_s  = REQ;
                bubble_s = 1'b1;
            end
        endcase
    end

    // Fetch control registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r      <= REQ;
            pc_r         <= PC_RESET;
            hold_pc_r    <= {N{1'b0}};
            hold_instr_r <= INSTR_BUBBLE;
            drop_addr_r  <= {N{1'b0}};
        end else begin
            state_r      <= state_s;
            pc_r         <= pc_s;
            hold_pc_r    <= hold_pc_s;
            hold_instr_r <= hold_instr_s;
            drop_addr_r  <= drop_addr_s;
        end
    end

    if_id_reg #(.N(N)) u_if_id_reg (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (load_s),
        .bubble   (bubble_s),
        .pc_in    (load_pc_s),
        .instr_in (load_instr_s),
        .pc       (IF_ID_pc_o),
        .instr    (IF_ID_instr_o),
        .valid    (IF_ID_valid_o)
    );

`ifdef FETCH_PERF_CNT_EN
    // Saturating counts of valid IF/ID loads and bubble insertions.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fetched_cnt_o <= 32'd0;
            bubble_cnt_o  <= 32'd0;
        end else begin
            if (load_s) begin
                fetched_cnt_o <= sat_inc32(fetched_cnt_o);
            end else begin
                fetched_cnt_o <= fetched_cnt_o;
            end
            if (bubble_s) begin
                bubble_cnt_o <= sat_inc32(bubble_cnt_o);
            end else begin
                bubble_cnt_o <= bubble_cnt_o;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage (default build, N=64, PC_RESET=0).
module tb_fetch_stage;

    logic        clk;
    logic        reset_n;
    logic        stall_i;
    logic        PCSrc_i;
    logic [63:0] branch_target_i;
    logic        imem_req_o;
    logic [63:0] imem_addr_o;
    logic        imem_ready_i;
    logic [31:0] imem_rdata_i;
    logic [63:0] IF_ID_pc_o;
    logic [31:0] IF_ID_instr_o;
    logic        IF_ID_valid_o;
    logic [10:0] Op_o;

    int checks   = 0;
    int failures = 0;

    fetch_stage #(.N(64), .PC_RESET(64'h0)) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .stall_i         (stall_i),
        .PCSrc_i         (PCSrc_i),
        .branch_target_i (branch_target_i),
        .imem_req_o      (imem_req_o),
        .imem_addr_o     (imem_addr_o),
        .imem_ready_i    (imem_ready_i),
        .imem_rdata_i    (imem_rdata_i),
        .IF_ID_pc_o      (IF_ID_pc_o),
        .IF_ID_instr_o   (IF_ID_instr_o),
        .IF_ID_valid_o   (IF_ID_valid_o),
        .Op_o            (Op_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] word_of(input logic [63:0] addr);
        return {8'hA5, addr[23:0]};
    endfunction

    function automatic logic [10:0] op_of(input logic [31:0] w);
        return w[31:21];
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_if(input string tag, input logic [63:0] pc, input logic [31:0] instr,
                          input logic valid);
        chk({tag, "_pc"},    IF_ID_pc_o,          pc);
        chk({tag, "_instr"}, {32'h0, IF_ID_instr_o}, {32'h0, instr});
        chk({tag, "_valid"}, {63'h0, IF_ID_valid_o}, {63'h0, valid});
        chk({tag, "_op"},    {53'h0, Op_o},       {53'h0, op_of(instr)});
    endtask

    task automatic chk_req(input string tag, input logic req, input logic [63:0] addr);
        chk({tag, "_req"}, {63'h0, imem_req_o}, {63'h0, req});
        if (req) begin
            chk({tag, "_addr"}, imem_addr_o, addr);
        end else begin
            checks = checks;
        end
    endtask

    initial begin
        reset_n         = 1'b0;
        stall_i         = 1'b0;
        PCSrc_i         = 1'b0;
        branch_target_i = 64'h0;
        imem_ready_i    = 1'b0;
        imem_rdata_i    = 32'h0;

        // Reset state
        repeat (2) @(negedge clk);
        chk_req("rst", 1'b0, 64'h0);
        chk_if("rst", 64'h0, 32'h0, 1'b0);

        // Zero-wait memory: 0, 4, 8 back to back
        reset_n = 1'b1; imem_ready_i = 1'b1; imem_rdata_i = word_of(64'h0);
        #1 chk_req("zw0", 1'b1, 64'h0);
        @(negedge clk);
        chk_req("zw1", 1'b1, 64'h4);
        chk_if("zw1", 64'h0, word_of(64'h0), 1'b1);
        imem_rdata_i = word_of(64'h4);
        @(negedge clk);
        chk_req("zw2", 1'b1, 64'h8);
        chk_if("zw2", 64'h4, word_of(64'h4), 1'b1);
        imem_rdata_i = word_of(64'h8);
        @(negedge clk);
        chk_req("zw3", 1'b1, 64'hC);
        chk_if("zw3", 64'h8, word_of(64'h8), 1'b1);

        // Stall while ready arrives: capture into HOLD
        stall_i = 1'b1; imem_ready_i = 1'b1; imem_rdata_i = 32'hF840_0000;
        @(negedge clk);
        chk_req("hold1", 1'b0, 64'h0);
        chk_if("hold1", 64'h8, word_of(64'h8), 1'b1);
        imem_ready_i = 1'b1; imem_rdata_i = 32'hDEAD_BEEF;
        @(negedge clk);
        chk_req("hold2", 1'b0, 64'h0);
        chk_if("hold2", 64'h8, word_of(64'h8), 1'b1);
        imem_ready_i = 1'b0;
        @(negedge clk);
        chk_req("hold3", 1'b0, 64'h0);
        stall_i = 1'b0;
        @(negedge clk);
        chk_if("unhold", 64'hC, 32'hF840_0000, 1'b1);
        chk("unhold_op", {53'h0, Op_o}, {53'h0, 11'h7C2});
        chk_req("unhold", 1'b1, 64'h10);

        // Request to 0x10 outstanding, then redirect to 0x100
        imem_ready_i = 1'b0;
        @(negedge clk);
        chk_if("wait10", 64'hC, 32'h0, 1'b0);
        chk_req("wait10", 1'b1, 64'h10);
        PCSrc_i = 1'b1; branch_target_i = 64'h100;
        @(negedge clk);
        chk_req("drop1", 1'b1, 64'h10);
        chk("drop1_valid", {63'h0, IF_ID_valid_o}, 64'h0);
        PCSrc_i = 1'b0;
        @(negedge clk);
        chk_req("drop2", 1'b1, 64'h10);
        imem_ready_i = 1'b1; imem_rdata_i = word_of(64'h10);
        @(negedge clk);
        chk_req("redir", 1'b1, 64'h100);
        chk("redir_valid", {63'h0, IF_ID_valid_o}, 64'h0);

        // Two-cycle ready delay at 0x100
        imem_ready_i = 1'b0;
        @(negedge clk);
        chk_req("dly1", 1'b1, 64'h100);
        chk("dly1_valid", {63'h0, IF_ID_valid_o}, 64'h0);
        chk("dly1_op", {53'h0, Op_o}, 64'h0);
        @(negedge clk);
        chk_req("dly2", 1'b1, 64'h100);
        chk("dly2_valid", {63'h0, IF_ID_valid_o}, 64'h0);
        imem_ready_i = 1'b1; imem_rdata_i = word_of(64'h100);
        @(negedge clk);
        chk_if("dly3", 64'h100, word_of(64'h100), 1'b1);
        chk_req("dly3", 1'b1, 64'h104);

        // Redirect and stall together in HOLD
        stall_i = 1'b1; imem_ready_i = 1'b1; imem_rdata_i = word_of(64'h104);
        @(negedge clk);
        chk_req("hb1", 1'b0, 64'h0);
        PCSrc_i = 1'b1; branch_target_i = 64'h200; imem_ready_i = 1'b0;
        @(negedge clk);
        chk("hb2_valid", {63'h0, IF_ID_valid_o}, 64'h0);
        chk("hb2_instr", {32'h0, IF_ID_instr_o}, 64'h0);
        chk_req("hb2", 1'b1, 64'h200);
        stall_i = 1'b0; PCSrc_i = 1'b0; imem_ready_i = 1'b1; imem_rdata_i = word_of(64'h200);
        @(negedge clk);
        chk_if("hb3", 64'h200, word_of(64'h200), 1'b1);

        // Redirect coinciding with ready: data dropped, new address next cycle
        PCSrc_i = 1'b1; branch_target_i = 64'h3C; imem_rdata_i = word_of(64'h204);
        @(negedge clk);
        chk_req("rr", 1'b1, 64'h3C);
        chk("rr_valid", {63'h0, IF_ID_valid_o}, 64'h0);
        PCSrc_i = 1'b0; imem_rdata_i = word_of(64'h3C);
        @(negedge clk);
        chk_if("pre40", 64'h3C, word_of(64'h3C), 1'b1);
        chk_req("pre40", 1'b1, 64'h40);

        // Reset in the middle of a request to 0x40
        stall_i = 1'b1; imem_ready_i = 1'b0;
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk_req("arst", 1'b0, 64'h0);
        chk_if("arst", 64'h0, 32'h0, 1'b0);
        @(negedge clk);
        reset_n = 1'b1; stall_i = 1'b0; imem_ready_i = 1'b1; imem_rdata_i = word_of(64'h0);
        #1 chk_req("post_rst", 1'b1, 64'h0);
        @(negedge clk);
        chk_if("post_rst", 64'h0, word_of(64'h0), 1'b1);
        chk_req("post_rst2", 1'b1, 64'h4);

        // PC wraps from all-ones-minus-3 to zero
        PCSrc_i = 1'b1; branch_target_i = 64'hFFFF_FFFF_FFFF_FFFC;
        @(negedge clk);
        chk_req("wrap1", 1'b1, 64'hFFFF_FFFF_FFFF_FFFC);
        PCSrc_i = 1'b0; imem_rdata_i = word_of(64'hFFFF_FFFF_FFFF_FFFC);
        @(negedge clk);
        chk_req("wrap2", 1'b1, 64'h0);
        chk_if("wrap2", 64'hFFFF_FFFF_FFFF_FFFC, word_of(64'hFFFF_FFFF_FFFF_FFFC), 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
